// File: rtl/norm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : norm_pkg
//  Purpose  : Shared defaults, types and helpers for the HOG block
//             normalization pipeline.
//  Contents : default geometry localparams, sum_width() helper,
//             3-bit shift config type, QBITS mode enum.
//  Revision : 1.0  initial release
// ============================================================================
package norm_pkg;

  localparam int NORM_BIN_WIDTH       = 14;
  localparam int NORM_BINS            = 9;
  localparam int NORM_CELLS_PER_BLOCK = 4;

  // Width that holds the sum of `cells` fields of `bw` bits without overflow.
  function automatic int sum_width(input int bw, input int cells);
    return bw + $clog2(cells);
  endfunction

  typedef logic [2:0] shift_cfg_t;

  typedef enum int {
    NORM_BINARY = 1,
    NORM_QUAD   = 2
  } qbits_mode_e;

endpackage
`default_nettype wire

// File: rtl/norm_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : norm_quantizer
//  Purpose  : Combinational quantizer for one histogram bin against the
//             block threshold T.
//  Ports    : i_bin    - bin magnitude (BIN_WIDTH)
//             i_thresh - block threshold T (SUM_WIDTH)
//             o_code   - QBITS=1: bin>=T ; QBITS=2: count of {T,2T,4T} <= bin
//  Revision : 1.0  initial release
// ============================================================================
module norm_quantizer #(
  parameter int BIN_WIDTH = 14,
  parameter int SUM_WIDTH = 16,
  parameter int QBITS     = 1
) (
  input  logic [BIN_WIDTH-1:0] i_bin,
  input  logic [SUM_WIDTH-1:0] i_thresh,
  output logic [QBITS-1:0]     o_code
);

  // Two guard bits so that 4T never wraps.
  localparam int c_CMP_W = SUM_WIDTH + 2;

  logic [c_CMP_W-1:0] w_bin_ext;
  logic [c_CMP_W-1:0] w_t1;
  logic               w_ge1;

  assign w_bin_ext = c_CMP_W'(i_bin);
  assign w_t1      = {2'b00, i_thresh};
  assign w_ge1     = (w_bin_ext >= w_t1);

  generate
    if (QBITS == 2) begin : g_quad
      logic [c_CMP_W-1:0] w_t2;
      logic [c_CMP_W-1:0] w_t4;
      logic               w_ge2;
      logic               w_ge4;

      assign w_t2   = {1'b0, i_thresh, 1'b0};
      assign w_t4   = {i_thresh, 2'b00};
      assign w_ge2  = (w_bin_ext >= w_t2);
      assign w_ge4  = (w_bin_ext >= w_t4);
      assign o_code = QBITS'({1'b0, w_ge1} + {1'b0, w_ge2} + {1'b0, w_ge4});
    end else begin : g_binary
      assign o_code = QBITS'(w_ge1);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/normalization_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : normalization_pipe
//  Purpose  : Two-stage valid/ready HOG block normalizer. Stage A captures
//             the bins and the threshold T = (sum of cell sums) >> cfg_shift;
//             stage B registers the per-bin quantized codes.
//  Ports    : clk, rst (sync, active high)
//             cfg_shift        - threshold shift, sampled with each block
//             in_valid/in_ready, k_border (border blocks are dropped)
//             block_histograms - CELLS x (BINS bins + 1 sum) x BIN_WIDTH
//             out_valid/out_ready, normalized_block (BINS*CELLS*QBITS)
//             block_count      - emitted blocks since reset, wraps at 2^16
//  Revision : 1.0  initial release
// ============================================================================
module normalization_pipe
  import norm_pkg::*;
#(
  parameter int BIN_WIDTH       = NORM_BIN_WIDTH,
  parameter int BINS            = NORM_BINS,
  parameter int CELLS_PER_BLOCK = NORM_CELLS_PER_BLOCK,
  parameter int QBITS           = 1,
  parameter int SUM_WIDTH       = sum_width(BIN_WIDTH, CELLS_PER_BLOCK),
  parameter int INPUT_WIDTH     = BIN_WIDTH * (BINS + 1) * CELLS_PER_BLOCK,
  parameter int OUTPUT_WIDTH    = BINS * CELLS_PER_BLOCK * QBITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              cfg_shift,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    k_border,
  input  logic [INPUT_WIDTH-1:0]  block_histograms,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] normalized_block,
  output logic [15:0]             block_count
);

  localparam int c_NUM_BINS = BINS * CELLS_PER_BLOCK;

  generate
    if ((QBITS != int'(NORM_BINARY)) && (QBITS != int'(NORM_QUAD))) begin : g_bad_qbits
      $error("normalization_pipe: QBITS must be 1 or 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic r_va;
  logic r_vb;
  logic w_b_adv;
  logic w_a_adv;
  logic w_accept;

  assign w_b_adv  = !r_vb || out_ready;
  assign w_a_adv  = r_va && w_b_adv;
  assign in_ready = !rst && (!r_va || w_b_adv);
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Stage A datapath: block sum, threshold and bin extraction
  // --------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0]            w_sum;
  logic [SUM_WIDTH-1:0]            w_thresh;
  shift_cfg_t                      w_shift;
  logic [c_NUM_BINS*BIN_WIDTH-1:0] w_bins;

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < CELLS_PER_BLOCK; c++) begin
      w_sum = w_sum + SUM_WIDTH'(block_histograms[(c*(BINS+1)+BINS)*BIN_WIDTH +: BIN_WIDTH]);
    end
  end

  assign w_shift  = cfg_shift;
  assign w_thresh = w_sum >> w_shift;

  // Repack bins densely, dropping the per-cell sum field.
  generate
    for (genvar gc = 0; gc < CELLS_PER_BLOCK; gc++) begin : g_cell
      for (genvar gb = 0; gb < BINS; gb++) begin : g_bin
        assign w_bins[(gc*BINS+gb)*BIN_WIDTH +: BIN_WIDTH] =
          block_histograms[(gc*(BINS+1)+gb)*BIN_WIDTH +: BIN_WIDTH];
      end
    end
  endgenerate

  logic [c_NUM_BINS*BIN_WIDTH-1:0] r_bins;
  logic [SUM_WIDTH-1:0]            r_thresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_va     <= 1'b0;
      r_bins   <= '0;
      r_thresh <= '0;
    end else begin
      if (w_accept && !k_border) begin
        r_va     <= 1'b1;
        r_bins   <= w_bins;
        r_thresh <= w_thresh;
      end else if (w_a_adv) begin
        // Covers the border-accept case too: A drains but is not refilled.
        r_va <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage B: quantize and register
  // --------------------------------------------------------------------------
  logic [OUTPUT_WIDTH-1:0] w_codes;
  logic [OUTPUT_WIDTH-1:0] r_codes;
  logic [15:0]             r_count;

  generate
    for (genvar gi = 0; gi < c_NUM_BINS; gi++) begin : g_quant
      norm_quantizer #(
        .BIN_WIDTH (BIN_WIDTH),
        .SUM_WIDTH (SUM_WIDTH),
        .QBITS     (QBITS)
      ) u_quant (
        .i_bin    (r_bins[gi*BIN_WIDTH +: BIN_WIDTH]),
        .i_thresh (r_thresh),
        .o_code   (w_codes[gi*QBITS +: QBITS])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vb    <= 1'b0;
      r_codes <= '0;
      r_count <= '0;
    end else begin
      if (w_b_adv) begin
        r_vb <= r_va;
        // Codes only load when a real block moves in, so an idle B keeps
        // its last value and a stalled B is untouched.
        if (r_va) begin
          r_codes <= w_codes;
        end
      end
      if (r_vb && out_ready) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign out_valid        = r_vb;
  assign normalized_block = r_codes;
  assign block_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_normalization_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_normalization_pipe
//  Purpose  : Directed self-checking bench; one binary (QBITS=1) and one
//             quad (QBITS=2) instance share all inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_normalization_pipe;

  localparam int IW  = 14 * 10 * 4;
  localparam int OWB = 36;
  localparam int OWQ = 72;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     cfg_shift;
  logic           in_valid;
  logic           k_border;
  logic [IW-1:0]  block_histograms;
  logic           out_ready;

  logic           b_in_ready, q_in_ready;
  logic           b_out_valid, q_out_valid;
  logic [OWB-1:0] b_norm;
  logic [OWQ-1:0] q_norm;
  logic [15:0]    b_count, q_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  normalization_pipe #(.QBITS(1)) dut_b (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_ready(b_in_ready), .k_border(k_border),
    .block_histograms(block_histograms), .out_valid(b_out_valid),
    .out_ready(out_ready), .normalized_block(b_norm), .block_count(b_count)
  );

  normalization_pipe #(.QBITS(2)) dut_q (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_ready(q_in_ready), .k_border(k_border),
    .block_histograms(block_histograms), .out_valid(q_out_valid),
    .out_ready(out_ready), .normalized_block(q_norm), .block_count(q_count)
  );

  // Block where bin b of every cell is v[b%4] and every cell sum field is sumv.
  function automatic logic [IW-1:0] mk_block(input int sumv, input int v0,
                                              input int v1, input int v2, input int v3);
    logic [IW-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 9; b++) begin
        v = (b % 4 == 0) ? v0 : (b % 4 == 1) ? v1 : (b % 4 == 2) ? v2 : v3;
        r[(c*10+b)*14 +: 14] = 14'(v);
      end
      r[(c*10+9)*14 +: 14] = 14'(sumv);
    end
    return r;
  endfunction

  // Expected vectors built from hand-derived per-position codes c[b%4].
  function automatic logic [OWQ-1:0] mk_exp_q(input int c0, input int c1,
                                               input int c2, input int c3);
    logic [OWQ-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < 36; i++) begin
      k = (i % 9) % 4;
      r[i*2 +: 2] = 2'((k == 0) ? c0 : (k == 1) ? c1 : (k == 2) ? c2 : c3);
    end
    return r;
  endfunction

  function automatic logic [OWB-1:0] mk_exp_b(input int c0, input int c1,
                                               input int c2, input int c3);
    logic [OWB-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < 36; i++) begin
      k = (i % 9) % 4;
      r[i] = 1'((k == 0) ? c0 : (k == 1) ? c1 : (k == 2) ? c2 : c3);
    end
    return r;
  endfunction

  // Offer one block and return just after the accepting edge (+1).
  task automatic send(input logic [IW-1:0] blk, input logic border, input logic [2:0] sh);
    int n;
    n = 0;
    in_valid = 1'b1; k_border = border; block_histograms = blk; cfg_shift = sh;
    #1;
    while (q_in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #2; n++;
    end
    if (q_in_ready !== 1'b1) begin
      $display("FAIL send_timeout: in_ready=%b required 1", q_in_ready);
      n_fail++; n_cmp++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; k_border = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (q_out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (q_out_valid !== 1'b1) begin
      $display("FAIL wait_out_valid: out_valid=%b required 1", q_out_valid);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; k_border = 1'b0; out_ready = 1'b1;
    cfg_shift = 3'd0; block_histograms = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (q_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b/%b required 0", b_out_valid, q_out_valid); n_fail++; end
    n_cmp++; if (q_norm !== '0 || b_norm !== '0) begin
      $display("FAIL reset_block: got %h/%h required 0", b_norm, q_norm); n_fail++; end
    n_cmp++; if (q_count !== 16'd0 || b_count !== 16'd0) begin
      $display("FAIL reset_count: got %0d/%0d required 0", b_count, q_count); n_fail++; end
    n_cmp++; if (q_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready: got %b/%b required 0", b_in_ready, q_in_ready); n_fail++; end
    rst = 1'b0;
    #1;
    n_cmp++; if (q_in_ready !== 1'b1) begin
      $display("FAIL reset_release_in_ready: got %b required 1", q_in_ready); n_fail++; end
    @(posedge clk); #1;
  endtask

  // S=256, shift 4 -> T=16; bins alternate 16/15.
  task automatic test_binary();
    out_ready = 1'b1;
    send(mk_block(64, 16, 15, 16, 15), 1'b0, 3'd4);
    n_cmp++; if (b_out_valid !== 1'b0) begin
      $display("FAIL binary_latency_early: out_valid=%b required 0", b_out_valid); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (b_out_valid !== 1'b1) begin
      $display("FAIL binary_latency: out_valid=%b required 1", b_out_valid); n_fail++; end
    n_cmp++; if (b_norm !== mk_exp_b(1, 0, 1, 0)) begin
      $display("FAIL binary_codes: got %h required %h", b_norm, mk_exp_b(1, 0, 1, 0)); n_fail++; end
    n_cmp++; if (q_norm !== mk_exp_q(1, 0, 1, 0)) begin
      $display("FAIL binary_quadview: got %h required %h", q_norm, mk_exp_q(1, 0, 1, 0)); n_fail++; end
    @(posedge clk); #1;
    exp_cnt++;
    n_cmp++; if (b_count !== 16'(exp_cnt) || b_out_valid !== 1'b0) begin
      $display("FAIL binary_count: count=%0d valid=%b required %0d/0", b_count, b_out_valid, exp_cnt); n_fail++; end
  endtask

  // Bins 15/16/32/64 against T=16.
  task automatic test_quad();
    out_ready = 1'b1;
    send(mk_block(64, 15, 16, 32, 64), 1'b0, 3'd4);
    wait_valid();
    n_cmp++; if (q_norm !== mk_exp_q(0, 1, 2, 3)) begin
      $display("FAIL quad_codes: got %h required %h", q_norm, mk_exp_q(0, 1, 2, 3)); n_fail++; end
    n_cmp++; if (b_norm !== mk_exp_b(0, 1, 1, 1)) begin
      $display("FAIL quad_binview: got %h required %h", b_norm, mk_exp_b(0, 1, 1, 1)); n_fail++; end
    @(posedge clk); #1;
    exp_cnt++;
    n_cmp++; if (q_count !== 16'(exp_cnt)) begin
      $display("FAIL quad_count: got %0d required %0d", q_count, exp_cnt); n_fail++; end
  endtask

  task automatic test_border();
    out_ready = 1'b1;
    in_valid = 1'b1; k_border = 1'b1; cfg_shift = 3'd4;
    block_histograms = mk_block(64, 64, 64, 64, 64);
    #1;
    n_cmp++; if (q_in_ready !== 1'b1) begin
      $display("FAIL border_in_ready: got %b required 1", q_in_ready); n_fail++; end
    @(posedge clk); #1;
    in_valid = 1'b0; k_border = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (q_out_valid !== 1'b0 || q_count !== 16'(exp_cnt)) begin
        $display("FAIL border_dropped: valid=%b count=%0d required 0/%0d", q_out_valid, q_count, exp_cnt); n_fail++; end
      @(posedge clk); #1;
    end
    send(mk_block(64, 15, 16, 32, 64), 1'b0, 3'd4);
    wait_valid();
    n_cmp++; if (q_norm !== mk_exp_q(0, 1, 2, 3)) begin
      $display("FAIL border_next: got %h required %h", q_norm, mk_exp_q(0, 1, 2, 3)); n_fail++; end
    @(posedge clk); #1;
    exp_cnt++;
  endtask

  // Block k: every bin = {0,16,32,64}[k], T=16 -> quad code k everywhere.
  task automatic test_backpressure();
    logic [IW-1:0] blks [4];
    int vals [4];
    int idx, nout, guard;
    logic acc;
    vals[0] = 0; vals[1] = 16; vals[2] = 32; vals[3] = 64;
    for (int k = 0; k < 4; k++) blks[k] = mk_block(64, vals[k], vals[k], vals[k], vals[k]);
    idx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; block_histograms = blks[idx]; cfg_shift = 3'd4;
      #1;
      acc = q_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (cyc >= 2) begin
        n_cmp++; if (q_out_valid !== 1'b1 || q_norm !== mk_exp_q(0, 0, 0, 0)) begin
          $display("FAIL bp_hold: valid=%b data=%h required 1/%h", q_out_valid, q_norm, mk_exp_q(0, 0, 0, 0)); n_fail++; end
      end
    end
    n_cmp++; if (idx !== 2) begin
      $display("FAIL bp_accepted: got %0d required 2", idx); n_fail++; end
    n_cmp++; if (q_in_ready !== 1'b0) begin
      $display("FAIL bp_in_ready: got %b required 0", q_in_ready); n_fail++; end
    out_ready = 1'b1;
    nout = 0; guard = 0;
    while (nout < 4 && guard < 30) begin
      if (q_out_valid === 1'b1) begin
        n_cmp++;
        if (q_norm !== mk_exp_q(nout, nout, nout, nout) ||
            b_norm !== mk_exp_b(nout > 0, nout > 0, nout > 0, nout > 0)) begin
          $display("FAIL bp_order%0d: got %h/%h required %h", nout, b_norm, q_norm,
                   mk_exp_q(nout, nout, nout, nout));
          n_fail++;
        end
        nout++;
      end
      in_valid = (idx < 4);
      if (idx < 4) block_histograms = blks[idx];
      #1;
      acc = in_valid && q_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    exp_cnt += 4;
    n_cmp++; if (idx !== 4 || nout !== 4 || q_count !== 16'(exp_cnt)) begin
      $display("FAIL bp_release: acc=%0d out=%0d count=%0d required 4/4/%0d", idx, nout, q_count, exp_cnt); n_fail++; end
  endtask

  task automatic test_max();
    out_ready = 1'b1;
    send(mk_block(16383, 16383, 16383, 16383, 16383), 1'b0, 3'd0);
    send(mk_block(0, 0, 0, 0, 0), 1'b0, 3'd0);
    n_cmp++; if (q_out_valid !== 1'b1 || q_norm !== '0 || b_norm !== '0) begin
      $display("FAIL max_codes: valid=%b got %h/%h required 0", q_out_valid, b_norm, q_norm); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (q_out_valid !== 1'b1 || q_norm !== {OWQ{1'b1}} || b_norm !== {OWB{1'b1}}) begin
      $display("FAIL zero_codes: valid=%b got %h/%h required all ones", q_out_valid, b_norm, q_norm); n_fail++; end
    @(posedge clk); #1;
    exp_cnt += 2;
    n_cmp++; if (q_out_valid !== 1'b0 || q_count !== 16'(exp_cnt)) begin
      $display("FAIL max_count: valid=%b count=%0d required 0/%0d", q_out_valid, q_count, exp_cnt); n_fail++; end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(mk_block(64, 64, 64, 64, 64), 1'b0, 3'd4);
    send(mk_block(64, 32, 32, 32, 32), 1'b0, 3'd4);
    rst = 1'b1;
    #1;
    n_cmp++; if (q_in_ready !== 1'b0) begin
      $display("FAIL rstmid_in_ready_high: got %b required 0", q_in_ready); n_fail++; end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    n_cmp++; if (q_out_valid !== 1'b0 || q_count !== 16'd0 || q_norm !== '0) begin
      $display("FAIL rstmid_state: valid=%b count=%0d data=%h required 0/0/0", q_out_valid, q_count, q_norm); n_fail++; end
    #1;
    n_cmp++; if (q_in_ready !== 1'b1) begin
      $display("FAIL rstmid_in_ready: got %b required 1", q_in_ready); n_fail++; end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (q_out_valid !== 1'b0) begin
        $display("FAIL rstmid_ghost: out_valid=%b required 0", q_out_valid); n_fail++; end
    end
    send(mk_block(64, 15, 16, 32, 64), 1'b0, 3'd4);
    wait_valid();
    n_cmp++; if (q_norm !== mk_exp_q(0, 1, 2, 3)) begin
      $display("FAIL rstmid_next: got %h required %h", q_norm, mk_exp_q(0, 1, 2, 3)); n_fail++; end
    @(posedge clk); #1;
    exp_cnt++;
    n_cmp++; if (q_count !== 16'(exp_cnt)) begin
      $display("FAIL rstmid_count: got %0d required %0d", q_count, exp_cnt); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_quad();
    test_border();
    test_backpressure();
    test_max();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
